// File: rtl/btn_updown_counter.sv
// Up/down counter driven by two raw active-low buttons: sync, debounce, hold auto-repeat, wrap/saturate, load.
// Latency: a steadily held button steps the count on edge DEBOUNCE_CYCLES+3; load lands on the next edge.
// Backpressure: none; steps are issued unconditionally and a step colliding with load is dropped.
module btn_updown_counter #(
    parameter int WIDTH           = 16,
    parameter int INIT            = 16'h05ec,
    parameter int MAX_VAL         = 2**WIDTH - 1,
    parameter int STEP            = 1,
    parameter int SATURATE        = 0,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             limit,
    output logic             held
);

    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_X  = MAX_X + 1'b1;
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] INIT_N = WIDTH'(INIT);

    localparam int             DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DLAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam int            TMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            TW       = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

    // Bit 0 = up button, bit 1 = down button; all levels are raw polarity (1 = released).
    logic [1:0]    sync1, sync2, deb;
    logic [DW-1:0] dcnt [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            deb     <= 2'b11;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            sync1 <= {btn_down, btn_up};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (dcnt[i] == DLAST) begin
                        deb[i]  <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    logic up_p, dn_p, own_p, other_p;
    assign up_p = ~deb[0];
    assign dn_p = ~deb[1];

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          dir_up, dir_up_nxt;
    logic          step_up, step_dn;

    assign own_p   = dir_up ? up_p : dn_p;
    assign other_p = dir_up ? dn_p : up_p;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        dir_up_nxt = dir_up;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        case (state)
            IDLE: begin
                if (up_p && dn_p) begin
                    state_nxt = LOCK;
                end else if (up_p || dn_p) begin
                    step_up    = up_p;
                    step_dn    = dn_p;
                    dir_up_nxt = up_p;
                    timer_nxt  = T_DELAY;
                    state_nxt  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                // Release wins over a repeat step falling due on the same edge.
                if (!own_p) begin
                    state_nxt = IDLE;
                end else if (other_p) begin
                    state_nxt = LOCK;
                end else if (timer == '0) begin
                    step_up   = dir_up;
                    step_dn   = !dir_up;
                    timer_nxt = T_PERIOD;
                    state_nxt = REPEAT;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            LOCK: begin
                if (!up_p && !dn_p)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arithmetic one bit wider than the count so the bound tests cannot overflow.
    logic [WIDTH:0]   cnt_x, up_sum;
    logic [WIDTH-1:0] count_nxt;
    logic             limit_nxt;

    assign cnt_x  = {1'b0, count};
    assign up_sum = cnt_x + STEP_X;

    always_comb begin
        count_nxt = count;
        limit_nxt = 1'b0;
        if (load) begin
            count_nxt = (load_value > MAX_N) ? MAX_N : load_value;
        end else if (step_up) begin
            if (up_sum > MAX_X) begin
                limit_nxt = 1'b1;
                count_nxt = (SATURATE != 0) ? MAX_N : WIDTH'(up_sum - MOD_X);
            end else begin
                count_nxt = WIDTH'(up_sum);
            end
        end else if (step_dn) begin
            if (cnt_x < STEP_X) begin
                limit_nxt = 1'b1;
                count_nxt = (SATURATE != 0) ? '0 : WIDTH'(cnt_x + MOD_X - STEP_X);
            end else begin
                count_nxt = WIDTH'(cnt_x - STEP_X);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            timer  <= '0;
            dir_up <= 1'b1;
            count  <= INIT_N;
            limit  <= 1'b0;
            held   <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            dir_up <= dir_up_nxt;
            count  <= count_nxt;
            limit  <= limit_nxt;
            held   <= (state_nxt == HOLD) || (state_nxt == REPEAT);
        end
    end

endmodule

// File: tb/tb_btn_updown_counter.sv
// Bench for btn_updown_counter: directed button/load vectors push timed expected events; monitors pop and compare.
// Latency: events are checked against the exact edge number they must appear on.
// Backpressure: none; any output change or limit pulse with no queued expectation is flagged.
module tb_btn_updown_counter;

    logic       clk;
    logic       reset;
    logic       btn_up_a, btn_down_a, load_a;
    logic [3:0] load_value_a;
    logic [3:0] count_a;
    logic       limit_a, held_a;
    logic       btn_up_s, btn_down_s, load_s;
    logic [3:0] load_value_s;
    logic [3:0] count_s;
    logic       limit_s, held_s;

    btn_updown_counter #(
        .WIDTH(4), .INIT(5), .MAX_VAL(9), .STEP(1), .SATURATE(0),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut_a (
        .clk(clk), .reset(reset), .btn_up(btn_up_a), .btn_down(btn_down_a),
        .load(load_a), .load_value(load_value_a),
        .count(count_a), .limit(limit_a), .held(held_a)
    );

    btn_updown_counter #(
        .WIDTH(4), .INIT(8), .MAX_VAL(9), .STEP(1), .SATURATE(1),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut_s (
        .clk(clk), .reset(reset), .btn_up(btn_up_s), .btn_down(btn_down_s),
        .load(load_s), .load_value(load_value_s),
        .count(count_s), .limit(limit_s), .held(held_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       lim;
        logic       hld;
        string      nm;
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t e_a, e_s;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    logic [3:0] prev_cnt_a, prev_cnt_s;
    logic       prev_hld_a, prev_hld_s;

    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input int at, input int c, input bit l, input bit h, input string n);
        exp_t e;
        e = '{at, 4'(c), l, h, n};
        q_a.push_back(e);
    endtask

    task automatic push_s(input int at, input int c, input bit l, input bit h, input string n);
        exp_t e;
        e = '{at, 4'(c), l, h, n};
        q_s.push_back(e);
    endtask

    task automatic chk(input string n, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", n, got, exp);
        end
    endtask

    task automatic cmp_evt(input string who, input exp_t e, input int c,
                           input logic [3:0] cnt, input logic lim, input logic hld);
        n_cmp++;
        if (c != e.cyc || cnt !== e.cnt || lim !== e.lim || hld !== e.hld) begin
            n_bad++;
            $display("FAIL %s/%s: got edge=%0d count=%0d limit=%b held=%b, required edge=%0d count=%0d limit=%b held=%b",
                     who, e.nm, c, cnt, lim, hld, e.cyc, e.cnt, e.lim, e.hld);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (count_a !== prev_cnt_a || limit_a !== 1'b0 || held_a !== prev_hld_a)) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a/unexpected: got edge=%0d count=%0d limit=%b held=%b, required no output event",
                         cyc, count_a, limit_a, held_a);
            end else begin
                e_a = q_a.pop_front();
                cmp_evt("a", e_a, cyc, count_a, limit_a, held_a);
            end
        end
        prev_cnt_a = count_a;
        prev_hld_a = held_a;
    end

    always @(negedge clk) begin
        if (mon_en && (count_s !== prev_cnt_s || limit_s !== 1'b0 || held_s !== prev_hld_s)) begin
            if (q_s.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL s/unexpected: got edge=%0d count=%0d limit=%b held=%b, required no output event",
                         cyc, count_s, limit_s, held_s);
            end else begin
                e_s = q_s.pop_front();
                cmp_evt("s", e_s, cyc, count_s, limit_s, held_s);
            end
        end
        prev_cnt_s = count_s;
        prev_hld_s = held_s;
    end

    // Load issued right after edge X lands on edge X+1.
    task automatic do_load(input int v, input int exp_cnt);
        int x;
        x = cyc;
        push_a(x + 1, exp_cnt, 1'b0, 1'b0, "load");
        load_a       = 1'b1;
        load_value_a = 4'(v);
        at_cyc(x + 1);
        load_a = 1'b0;
    endtask

    int t;

    initial begin
        reset = 1'b0;
        btn_up_a = 1'b0; btn_down_a = 1'b0; load_a = 1'b0; load_value_a = '0;
        btn_up_s = 1'b0; btn_down_s = 1'b0; load_s = 1'b0; load_value_s = '0;

        // Reset with buttons pushed, then release everything.
        at_cyc(5);
        reset = 1'b1;
        btn_up_a = 1'b1; btn_down_a = 1'b1;
        btn_up_s = 1'b1; btn_down_s = 1'b1;
        @(negedge clk);
        chk("reset_count_a", int'(count_a), 5);
        chk("reset_limit_a", int'(limit_a), 0);
        chk("reset_held_a",  int'(held_a),  0);
        chk("reset_count_s", int'(count_s), 8);
        chk("reset_held_s",  int'(held_s),  0);
        mon_en = 1'b1;
        at_cyc(60);
        chk("idle_count_a", int'(count_a), 5);

        // Bounce: five 2-low/2-high cycles, then steady low.
        t = cyc;
        push_a(t + 27, 6, 1'b0, 1'b1, "bounce_step");
        push_a(t + 35, 6, 1'b0, 1'b0, "bounce_release");
        for (int i = 0; i < 5; i++) begin
            at_cyc(t + 4*i);     btn_up_a = 1'b0;
            at_cyc(t + 4*i + 2); btn_up_a = 1'b1;
        end
        at_cyc(t + 20); btn_up_a = 1'b0;
        at_cyc(t + 28); btn_up_a = 1'b1;
        at_cyc(t + 50);
        do_load(5, 5);

        // Auto-repeat down through the wrap.
        t = cyc + 5;
        push_a(t + 7,  4, 1'b0, 1'b1, "rep_first");
        push_a(t + 15, 3, 1'b0, 1'b1, "rep_delay");
        push_a(t + 18, 2, 1'b0, 1'b1, "rep_p1");
        push_a(t + 21, 1, 1'b0, 1'b1, "rep_p2");
        push_a(t + 24, 0, 1'b0, 1'b1, "rep_p3");
        push_a(t + 27, 9, 1'b1, 1'b1, "rep_wrap");
        push_a(t + 30, 8, 1'b0, 1'b1, "rep_p5");
        push_a(t + 33, 7, 1'b0, 1'b1, "rep_p6");
        push_a(t + 36, 6, 1'b0, 1'b1, "rep_p7");
        push_a(t + 39, 5, 1'b0, 1'b1, "rep_p8");
        push_a(t + 42, 4, 1'b0, 1'b1, "rep_p9");
        push_a(t + 45, 3, 1'b0, 1'b1, "rep_p10");
        push_a(t + 47, 3, 1'b0, 1'b0, "rep_release");
        at_cyc(t);      btn_down_a = 1'b0;
        at_cyc(t + 40); btn_down_a = 1'b1;
        at_cyc(t + 60);
        do_load(5, 5);

        // Both pressed: LOCK freezes the count until both are released.
        t = cyc + 5;
        push_a(t + 7,  6, 1'b0, 1'b1, "both_step");
        push_a(t + 10, 6, 1'b0, 1'b0, "both_lock");
        push_a(t + 57, 7, 1'b0, 1'b1, "both_idle_step");
        push_a(t + 65, 7, 1'b0, 1'b0, "both_idle_release");
        at_cyc(t);      btn_up_a   = 1'b0;
        at_cyc(t + 3);  btn_down_a = 1'b0;
        at_cyc(t + 20); btn_down_a = 1'b1;
        at_cyc(t + 40); btn_up_a   = 1'b1;
        at_cyc(t + 50); btn_up_a   = 1'b0;
        at_cyc(t + 58); btn_up_a   = 1'b1;
        at_cyc(t + 80);

        // Load collides with the first repeat step: clipped, step dropped, cadence kept.
        t = cyc + 5;
        push_a(t + 7,  8, 1'b0, 1'b1, "coll_step");
        push_a(t + 15, 9, 1'b0, 1'b1, "coll_load");
        push_a(t + 18, 0, 1'b1, 1'b1, "coll_wrap");
        push_a(t + 21, 1, 1'b0, 1'b1, "coll_p2");
        push_a(t + 24, 2, 1'b0, 1'b1, "coll_p3");
        push_a(t + 26, 2, 1'b0, 1'b0, "coll_release");
        at_cyc(t);      btn_up_a = 1'b0;
        at_cyc(t + 14); load_a = 1'b1; load_value_a = 4'd12;
        at_cyc(t + 15); load_a = 1'b0;
        at_cyc(t + 19); btn_up_a = 1'b1;
        at_cyc(t + 40);

        // Saturate: clamps at 9 and pulses limit on each attempted step.
        t = cyc + 5;
        push_s(t + 7,  9, 1'b0, 1'b1, "sat_step");
        push_s(t + 15, 9, 1'b1, 1'b1, "sat_clamp1");
        push_s(t + 18, 9, 1'b1, 1'b1, "sat_clamp2");
        push_s(t + 21, 9, 1'b1, 1'b1, "sat_clamp3");
        push_s(t + 24, 9, 1'b1, 1'b1, "sat_clamp4");
        push_s(t + 27, 9, 1'b0, 1'b0, "sat_release");
        at_cyc(t);      btn_up_s = 1'b0;
        at_cyc(t + 20); btn_up_s = 1'b1;
        at_cyc(t + 40);

        chk("pending_a", q_a.size(), 0);
        chk("pending_s", q_s.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_updown_counter.md
Name: btn_updown_counter

Overview:
Parametrised up/down counter driven directly by two raw active-low push buttons. It adds per-button synchronisation and debounce, press-and-hold auto-repeat, programmable step and modulus, wrap or saturate mode, and a synchronous load. Its count output feeds the LED7Seg display path. It replaces the free-running-divider counter process in top-level designs.

Parameters:
WIDTH, 16, counter width in bits.
INIT, 16'h05ec, count value after reset (truncated to WIDTH; must be <= MAX_VAL).
MAX_VAL, 2**WIDTH-1, largest legal count; legal range 0..MAX_VAL.
STEP, 1, increment/decrement per step (1..MAX_VAL).
SATURATE, 0, 0 = modulo wrap at bounds, 1 = clamp at bounds.
DEBOUNCE_CYCLES, 500000, consecutive stable clocks (>=1) required to accept a button level change.
REPEAT_DELAY, 25000000, clocks (>=1) from the first step to the first auto-repeat step.
REPEAT_PERIOD, 5000000, clocks (>=1) between subsequent auto-repeat steps.

Ports:
clk  in  1  system clock, 50 MHz, all logic on posedge.
reset  in  1  asynchronous active-low reset (0 = reset asserted).
btn_up  in  1  raw button, 0 = pushed, asynchronous.
btn_down  in  1  raw button, 0 = pushed, asynchronous.
load  in  1  synchronous load strobe, active-high, already in clk domain.
load_value  in  WIDTH  value to load.
count  out  WIDTH  current count.
limit  out  1  one-cycle pulse when a step wraps (SATURATE=0) or is clamped (SATURATE=1).
held  out  1  1 while the FSM is in HOLD or REPEAT.

Behaviour:
- Reset (reset=0, asynchronous): count=INIT, limit=0, held=0, FSM=IDLE. Synchronisers are cleared to "released" (1), debounced levels are set to released, and all timers are cleared. Assertion mid-press aborts the press. After release from reset, a still-held button must pass the full debounce before it is accepted.
- Synchroniser: 2 flops per button. Debounce: a per-button counter increments while the synchronised level differs from the debounced level, and clears when they match. When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press = debounced level goes 1 to 0. Let up_p and dn_p be the debounced pressed states.
- FSM states: IDLE, HOLD, REPEAT, LOCK.
  - IDLE: if exactly one of up_p/dn_p is set, issue one step in that direction, load timer=REPEAT_DELAY-1, and go to HOLD. If both are set, go to LOCK with no step.
  - HOLD: if the held button is released, go to IDLE. If the other button becomes pressed, go to LOCK. Otherwise, when timer==0, issue a step, load timer=REPEAT_PERIOD-1, and go to REPEAT. Otherwise decrement timer.
  - REPEAT: same exit rules as HOLD. When timer==0, issue a step and reload REPEAT_PERIOD-1.
  - LOCK: wait until both buttons are released, then go to IDLE. No steps are issued in LOCK.
- Latency: with the button held steadily low from its first sampled edge, count changes on clock edge 2+DEBOUNCE_CYCLES+1.
  - The first repeat step occurs REPEAT_DELAY clocks after the first step.
  - Each later repeat step occurs REPEAT_PERIOD clocks after the previous step.
- Arithmetic is performed at WIDTH+1 bits with no silent overflow.
  - Up step: if count+STEP > MAX_VAL, the result is (count+STEP)-(MAX_VAL+1) in wrap mode, or MAX_VAL in saturate mode; limit=1 for one cycle.
  - Down step: if count < STEP, the result is count+(MAX_VAL+1)-STEP in wrap mode, or 0 in saturate mode; limit=1.
  - In saturate mode, limit also pulses when a step is attempted while count is already at the bound.
- load: on the clock where load=1, count=min(load_value, MAX_VAL). Load takes priority over a step due on the same clock; that step is discarded (not deferred) and limit=0. The FSM and timers are unaffected by load.
- limit and held are registered outputs. limit is high only on the cycle immediately following the step edge, together with the updated count.

Test Plan:
Bench parameters: WIDTH=4, INIT=5, MAX_VAL=9, STEP=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, SATURATE=0 unless stated.
- Reset: hold reset=0 with both buttons pushed, then release reset and keep buttons released -> count=5, limit=0, held=0; count stays 5 for 50 clocks.
- Bounce: toggle btn_up every 2 clocks for 20 clocks, then hold it 0 -> no step during bouncing; exactly one step (count=6) at edge 7 after steady low begins.
- Auto-repeat: hold btn_down low for 40 clocks, then release -> count 5,4 at edge 7, 3 at +8, then 2,1,0 every 3 clocks, then 9 with limit pulse. No further steps after release is debounced.
- Saturate: SATURATE=1, INIT=8, hold btn_up for 20 clocks -> count 9 at first step. Second step leaves count=9 with limit=1 for one cycle. held=1 throughout.
- Both pressed: press btn_up, then press btn_down 2 clocks after up's step -> FSM goes to LOCK, count frozen at 6. Releasing only btn_down gives no steps; releasing both returns to IDLE.
- Load collision: load=1 with load_value=12 on the exact edge of a due up-step -> count=9 (clipped), limit=0, and the next repeat step still occurs REPEAT_PERIOD later, giving 0 with limit=1.
